// File: rtl/bsg_front_side_bus_hop_out_no_fc.sv
`default_nettype none
// ============================================================================
// Module   : bsg_front_side_bus_hop_out_no_fc
// Brief    : Bus hop output stage; merges pass-through traffic with a local
//            injection FIFO and registers the result toward the next hop.
// Revision : 1.0
// ============================================================================
module bsg_front_side_bus_hop_out_no_fc #(
    parameter int width_p            = 8,   // set by the instantiating hop
    parameter int els_p              = 2,
    parameter int starve_threshold_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] bus_data_i,
    input  logic               bus_v_i,
    input  logic [width_p-1:0] local_data_i,
    input  logic               local_v_i,
    output logic               local_ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    output logic               starve_o
);

    localparam int PTR_W = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int CNT_W = $clog2(els_p + 1);
    localparam int ST_W  = $clog2(starve_threshold_p + 1);

    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(els_p - 1);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(els_p);
    localparam logic [ST_W-1:0]  c_ST_MAX   = ST_W'(starve_threshold_p);

    logic [width_p-1:0] mem_q [els_p];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ST_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic               v_q, v_d;
    logic [width_p-1:0] data_q, data_d;

    logic w_nonempty;
    logic w_enq;
    logic w_deq;

    assign w_nonempty    = (count_q != '0);
    assign local_ready_o = (count_q < c_CNT_FULL);
    assign w_enq         = local_v_i & local_ready_o;
    // The bus has no backpressure, so the FIFO head only moves in idle slots.
    assign w_deq         = ~bus_v_i & w_nonempty;

    always_comb begin
        v_d          = 1'b0;
        data_d       = data_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        starve_cnt_d = starve_cnt_q;

        if (bus_v_i) begin
            v_d    = 1'b1;
            data_d = bus_data_i;
        end else if (w_nonempty) begin
            v_d    = 1'b1;
            data_d = mem_q[rd_ptr_q];
        end

        if (w_deq) begin
            rd_ptr_d = (rd_ptr_q == c_PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        if (w_enq) begin
            wr_ptr_d = (wr_ptr_q == c_PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end

        case ({w_enq, w_deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (!w_nonempty || w_deq) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != c_ST_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q          <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
        end else begin
            v_q          <= v_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by v_q and count_q.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
        if (w_enq) begin
            mem_q[wr_ptr_q] <= local_data_i;
        end
    end

    assign v_o      = v_q;
    assign data_o   = data_q;
    assign starve_o = (starve_cnt_q == c_ST_MAX);

endmodule
`default_nettype wire

// File: tb/tb_bsg_front_side_bus_hop_out_no_fc.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_front_side_bus_hop_out_no_fc
// Brief    : Directed self-checking bench for the bus hop output stage.
// Revision : 1.0
// ============================================================================
module tb_bsg_front_side_bus_hop_out_no_fc;

    localparam int c_W = 8;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic [c_W-1:0] bus_data_i;
    logic           bus_v_i;
    logic [c_W-1:0] local_data_i;
    logic           local_v_i;
    logic           local_ready_o;
    logic [c_W-1:0] data_o;
    logic           v_o;
    logic           starve_o;

    int n_checks = 0;
    int n_errors = 0;

    bsg_front_side_bus_hop_out_no_fc #(
        .width_p           (c_W),
        .els_p             (2),
        .starve_threshold_p(4)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .bus_data_i   (bus_data_i),
        .bus_v_i      (bus_v_i),
        .local_data_i (local_data_i),
        .local_v_i    (local_v_i),
        .local_ready_o(local_ready_o),
        .data_o       (data_o),
        .v_o          (v_o),
        .starve_o     (starve_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i      = 1'b1;
        bus_v_i      = 1'b0;
        bus_data_i   = '0;
        local_v_i    = 1'b0;
        local_data_i = '0;
        step();
        step();
        reset_i = 1'b0;
        check_eq("rst_v", 32'(v_o), 32'd0);
        check_eq("rst_ready", 32'(local_ready_o), 32'd1);
        check_eq("rst_starve", 32'(starve_o), 32'd0);
        step();
        check_eq("idle_v", 32'(v_o), 32'd0);

        // Bus only
        bus_v_i = 1'b1; bus_data_i = 8'hA1; step();
        check_eq("bus_v1", 32'(v_o), 32'd1);
        check_eq("bus_d1", 32'(data_o), 32'hA1);
        bus_data_i = 8'hA2; step();
        check_eq("bus_d2", 32'(data_o), 32'hA2);
        bus_data_i = 8'hA3; step();
        check_eq("bus_d3", 32'(data_o), 32'hA3);
        check_eq("bus_starve", 32'(starve_o), 32'd0);
        bus_v_i = 1'b0; step();
        check_eq("bus_idle_v", 32'(v_o), 32'd0);

        // Local only: enqueue in cycle 0, emitted in cycle 2
        local_v_i = 1'b1; local_data_i = 8'h55;
        check_eq("loc_ready0", 32'(local_ready_o), 32'd1);
        step();
        local_v_i = 1'b0;
        check_eq("loc_v_c1", 32'(v_o), 32'd0);
        check_eq("loc_ready1", 32'(local_ready_o), 32'd1);
        step();
        check_eq("loc_v_c2", 32'(v_o), 32'd1);
        check_eq("loc_d_c2", 32'(data_o), 32'h55);
        step();
        check_eq("loc_v_c3", 32'(v_o), 32'd0);

        // Collision: bus wins for three cycles, local follows
        local_v_i = 1'b1; local_data_i = 8'h11; step();
        local_v_i = 1'b0;
        bus_v_i = 1'b1; bus_data_i = 8'hB0; step();
        check_eq("col_d_c2", 32'(data_o), 32'hB0);
        bus_data_i = 8'hB1; step();
        check_eq("col_d_c3", 32'(data_o), 32'hB1);
        bus_data_i = 8'hB2; step();
        check_eq("col_d_c4", 32'(data_o), 32'hB2);
        bus_v_i = 1'b0; step();
        check_eq("col_v_c5", 32'(v_o), 32'd1);
        check_eq("col_d_c5", 32'(data_o), 32'h11);
        step();
        check_eq("col_v_c6", 32'(v_o), 32'd0);

        // Full FIFO under a busy bus
        bus_v_i = 1'b1; bus_data_i = 8'hC0;
        local_v_i = 1'b1; local_data_i = 8'h01;
        step();
        check_eq("full_ready1", 32'(local_ready_o), 32'd1);
        local_data_i = 8'h02; step();
        check_eq("full_ready2", 32'(local_ready_o), 32'd0);
        local_data_i = 8'h03; step();
        check_eq("full_held", 32'(local_ready_o), 32'd0);
        check_eq("full_bus_d", 32'(data_o), 32'hC0);
        bus_v_i = 1'b0; step();
        check_eq("full_d1", 32'(data_o), 32'h01);
        check_eq("full_reready", 32'(local_ready_o), 32'd1);
        step();
        local_v_i = 1'b0;
        check_eq("full_d2", 32'(data_o), 32'h02);
        check_eq("full_ready3", 32'(local_ready_o), 32'd1);
        step();
        check_eq("full_v3", 32'(v_o), 32'd1);
        check_eq("full_d3", 32'(data_o), 32'h03);
        step();
        check_eq("full_v_end", 32'(v_o), 32'd0);

        // Starvation with threshold 4
        local_v_i = 1'b1; local_data_i = 8'h77; step();
        local_v_i = 1'b0;
        bus_v_i = 1'b1; bus_data_i = 8'hD0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check_eq($sformatf("stv_blk%0d", i), 32'(starve_o), (i == 4) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq($sformatf("stv_hold%0d", i), 32'(starve_o), 32'd1);
        end
        bus_v_i = 1'b0; step();
        check_eq("stv_clear", 32'(starve_o), 32'd0);
        check_eq("stv_v", 32'(v_o), 32'd1);
        check_eq("stv_d", 32'(data_o), 32'h77);
        step();
        check_eq("stv_v_end", 32'(v_o), 32'd0);

        // Reset mid-operation with two packets buffered
        bus_v_i = 1'b1; bus_data_i = 8'hE0;
        local_v_i = 1'b1; local_data_i = 8'h21; step();
        local_data_i = 8'h22; step();
        local_v_i = 1'b0;
        check_eq("mrst_pre_v", 32'(v_o), 32'd1);
        check_eq("mrst_pre_ready", 32'(local_ready_o), 32'd0);
        reset_i = 1'b1; step();
        reset_i = 1'b0; bus_v_i = 1'b0;
        check_eq("mrst_v", 32'(v_o), 32'd0);
        check_eq("mrst_ready", 32'(local_ready_o), 32'd1);
        check_eq("mrst_starve", 32'(starve_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("mrst_drop%0d", i), 32'(v_o), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bsg_front_side_bus_hop_out_no_fc.md
# bsg_front_side_bus_hop_out_no_fc

Output side of one front side bus hop. It merges pass-through bus traffic with packets injected by the local node, and registers the result onto the link to the next hop. It sits directly downstream of the hop-in stage: `bus_data_i`/`bus_v_i` connect to the hop-in's "next switch" output. The bus has no backward flow control, so pass-through traffic always wins. Local packets are buffered in a small FIFO and inserted into idle bus slots.

## Interface
- `width_p`, default "inv" (must be set): packet width in bits.
- `els_p`, default 2: local injection FIFO depth; must be ≥ 2.
- `starve_threshold_p`, default 16: number of blocked cycles at which `starve_o` asserts; must be ≥ 1.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `bus_data_i`  in  `width_p`  pass-through packet from the upstream hop-in.
- `bus_v_i`  in  1  pass-through valid; cannot be stalled.
- `local_data_i`  in  `width_p`  packet from the local node.
- `local_v_i`  in  1  local valid.
- `local_ready_o`  out  1  FIFO can accept; a transfer occurs when `local_v_i & local_ready_o`.
- `data_o`  out  `width_p`  registered packet to the next hop.
- `v_o`  out  1  registered valid to the next hop.
- `starve_o`  out  1  local head has been blocked for `starve_threshold_p` bus-busy cycles.

## Operation
- Output register holds `v_r` (reset) and `data_r` (not reset).
- Each cycle the output register is loaded as follows:
  - If `bus_v_i`=1: `v_r`←1 and `data_r`←`bus_data_i`. The FIFO is untouched.
  - Else if the FIFO is non-empty: `v_r`←1, `data_r`←FIFO head, and the head is dequeued.
  - Else: `v_r`←0 and `data_r` holds its value. Do not toggle data when idle.
- Local FIFO:
  - `els_p` entries with an occupancy counter of width `$clog2(els_p+1)`.
  - `local_ready_o` = (count < `els_p`), decoded from registered state only.
  - No bypass: an enqueued packet becomes the head no earlier than the next cycle.
  - Simultaneous enqueue and dequeue leaves the count unchanged. Packets leave in strict FIFO order.
- Starvation counter:
  - Saturating, width `$clog2(starve_threshold_p+1)`.
  - Increments when the FIFO is non-empty and `bus_v_i`=1, i.e. the head is blocked.
  - Clears to 0 on a dequeue or whenever the FIFO is empty.
  - Holds at `starve_threshold_p` once it gets there.
  - `starve_o` = (counter == `starve_threshold_p`). It is advisory only; arbitration priority does not change.
- Packets are never dropped. Bus traffic never waits. Local traffic may wait indefinitely under a saturated bus.

## Timing
- Bus path latency is 1 cycle: `bus_v_i` at cycle t gives `v_o` at t+1 with identical data.
- Local path minimum latency is 2 cycles:
  - Enqueue at edge t.
  - The packet is the head during cycle t+1.
  - If `bus_v_i`=0 in cycle t+1, `v_o`=1 in cycle t+2.
- `local_ready_o` deasserts in the cycle after the enqueue that fills the FIFO. It reasserts in the cycle after the next dequeue.
- While the FIFO is full, `local_ready_o`=0. An enqueue concurrent with a dequeue is therefore impossible when full.
- Reset values, effective in the cycle after `reset_i` is sampled high:
  - `v_o`=0
  - `local_ready_o`=1
  - `starve_o`=0
  - FIFO count = 0
  - starvation counter = 0
  - `data_o` is undefined until the first valid; benches must not check it.
- Reset mid-operation discards all buffered local packets and any in-flight output. Inputs presented during reset are ignored.
- Empty FIFO with `bus_v_i`=0: `v_o`=0 next cycle.
- FIFO read and write pointers wrap modulo `els_p`. `els_p` need not be a power of two.

## Test plan
- Bus only: `bus_v_i`=1 with data 0xA1, 0xA2, 0xA3 on consecutive cycles, local idle. Expect `v_o`=1 with 0xA1, 0xA2, 0xA3 one cycle later each, and `starve_o`=0.
- Local only: enqueue 0x55 at cycle 0 with the bus idle. Expect `v_o`=1, `data_o`=0x55 at cycle 2 and `v_o`=0 at cycle 3. `local_ready_o` stays 1 with `els_p`=2.
- Collision:
  - Enqueue 0x11 at cycle 0.
  - Hold `bus_v_i`=1 (data 0xB0..0xB2) for cycles 1–3.
  - Expect `data_o` 0xB0, 0xB1, 0xB2 at cycles 2–4, then 0x11 at cycle 5.
- Full FIFO:
  - Keep `bus_v_i`=1 and offer 0x01, 0x02, 0x03 back-to-back.
  - Expect `local_ready_o`=0 after the second accept, with 0x03 held off.
  - Drop the bus. Expect 0x01 then 0x02, with ready reasserting one cycle after the first dequeue, then 0x03 accepted and emitted in order.
- Starvation (`starve_threshold_p`=4):
  - One local packet pending under a continuous bus.
  - Expect `starve_o`=1 after 4 blocked cycles and held while the bus stays busy.
  - Expect it to clear the cycle after the dequeue.
- Reset mid-operation: two packets buffered and `v_o`=1. Assert `reset_i` for 1 cycle. Expect `v_o`=0, `local_ready_o`=1, `starve_o`=0, and the buffered packets never emitted.
